// File: rtl/pc_flags_pkg.sv
// Shared definitions for the program-counter / condition-flags unit.
package pc_flags_pkg;

    // FSM state encoding
    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

    // Bit positions inside the flags vector
    localparam int unsigned FlagZ    = 0;
    localparam int unsigned FlagL    = 1;
    localparam int unsigned FlagG    = 2;
    localparam int unsigned NumFlags = 3;

    // Branch kinds, listed from highest to lowest priority
    typedef enum logic [2:0] {
        BrNone = 3'd0,
        BrJump = 3'd1,
        BrJz   = 3'd2,
        BrJnz  = 3'd3,
        BrJl   = 3'd4,
        BrJg   = 3'd5
    } br_kind_e;

    // Select the single highest-priority strobe; lower ones are ignored
    function automatic br_kind_e branch_kind(input logic jump, input logic jz,
                                             input logic jnz, input logic jl,
                                             input logic jg);
        br_kind_e kind;
        kind = BrNone;
        if (jump) begin
            kind = BrJump;
        end else if (jz) begin
            kind = BrJz;
        end else if (jnz) begin
            kind = BrJnz;
        end else if (jl) begin
            kind = BrJl;
        end else if (jg) begin
            kind = BrJg;
        end
        return kind;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision from decoder strobes and registered flags.
module branch_resolve
    import pc_flags_pkg::*;
(
    input  logic                is_jz,
    input  logic                is_jnz,
    input  logic                is_jl,
    input  logic                is_jg,
    input  logic                is_jump,
    input  logic [NumFlags-1:0] flags,
    output logic                take
);

    br_kind_e kind;

    // Evaluate only the winning strobe against its flag condition
    always_comb begin
        kind = branch_kind(is_jump, is_jz, is_jnz, is_jl, is_jg);
        take = 1'b0;
        case (kind)
            BrJump:  take = 1'b1;
            BrJz:    take = flags[FlagZ];
            BrJnz:   take = ~flags[FlagZ];
            BrJl:    take = flags[FlagL];
            BrJg:    take = flags[FlagG];
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flags_unit.sv
// Program counter, condition flags and post-branch squash control.
module pc_flags_unit
    import pc_flags_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  instr_valid,
    input  logic                  flags_write,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  is_jz,
    input  logic                  is_jnz,
    input  logic                  is_jl,
    input  logic                  is_jg,
    input  logic                  is_jump,
    input  logic [PC_WIDTH-1:0]   target,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  flag_z,
    output logic                  flag_l,
    output logic                  flag_g,
    output logic                  branch_taken,
    output logic                  flush
);

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [NumFlags-1:0]   flags_q;
    logic [NumFlags-1:0]   flags_new;
    logic                  branch_taken_q;
    logic                  effective;
    logic                  take_raw;

    branch_resolve u_branch_resolve (
        .is_jz   (is_jz),
        .is_jnz  (is_jnz),
        .is_jl   (is_jl),
        .is_jg   (is_jg),
        .is_jump (is_jump),
        .flags   (flags_q),
        .take    (take_raw)
    );

    // Qualify the slot and compute the candidate flags from the ALU result
    always_comb begin
        effective        = instr_valid && !stall && (state_q == StRun);
        flags_new        = '0;
        flags_new[FlagZ] = (alu_result == '0);
        flags_new[FlagL] = alu_result[DATA_WIDTH-1];
        flags_new[FlagG] = !flags_new[FlagZ] && !flags_new[FlagL];
    end

    // FSM, PC and flags; the branch sees flags_q, so a same-cycle write is not visible to it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            pc_q           <= '0;
            flags_q        <= '0;
            branch_taken_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                StRun: begin
                    if (effective && flags_write) begin
                        flags_q <= flags_new;
                    end
                    if (effective && take_raw) begin
                        pc_q           <= target;
                        branch_taken_q <= 1'b1;
                        state_q        <= StFlush;
                    end else begin
                        pc_q           <= pc_q + PC_WIDTH'(1);
                        branch_taken_q <= 1'b0;
                    end
                end
                StFlush: begin
                    pc_q           <= pc_q + PC_WIDTH'(1);
                    branch_taken_q <= 1'b0;
                    state_q        <= StRun;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        pc           = pc_q;
        flag_z       = flags_q[FlagZ];
        flag_l       = flags_q[FlagL];
        flag_g       = flags_q[FlagG];
        branch_taken = branch_taken_q;
        flush        = (state_q == StFlush);
    end

endmodule

// File: tb/tb_pc_flags_unit.sv
// Directed self-checking bench for pc_flags_unit.
module tb_pc_flags_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        instr_valid;
    logic        flags_write;
    logic [15:0] alu_result;
    logic        is_jz;
    logic        is_jnz;
    logic        is_jl;
    logic        is_jg;
    logic        is_jump;
    logic [7:0]  target;
    logic [7:0]  pc;
    logic        flag_z;
    logic        flag_l;
    logic        flag_g;
    logic        branch_taken;
    logic        flush;

    int checks = 0;
    int errors = 0;

    pc_flags_unit #(
        .PC_WIDTH   (8),
        .DATA_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .instr_valid  (instr_valid),
        .flags_write  (flags_write),
        .alu_result   (alu_result),
        .is_jz        (is_jz),
        .is_jnz       (is_jnz),
        .is_jl        (is_jl),
        .is_jg        (is_jg),
        .is_jump      (is_jump),
        .target       (target),
        .pc           (pc),
        .flag_z       (flag_z),
        .flag_l       (flag_l),
        .flag_g       (flag_g),
        .branch_taken (branch_taken),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {g, l, z}
    task automatic chk_state(input string tag, input logic [7:0] e_pc, input logic [2:0] e_flags,
                             input logic e_bt, input logic e_flush);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".flags"}, 32'({flag_g, flag_l, flag_z}), 32'(e_flags));
        chk({tag, ".bt"}, 32'(branch_taken), 32'(e_bt));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        flags_write = 1'b0;
        is_jz       = 1'b0;
        is_jnz      = 1'b0;
        is_jl       = 1'b0;
        is_jg       = 1'b0;
        is_jump     = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        instr_valid = 1'b0;
        alu_result  = '0;
        target      = '0;
        clear_strobes();
        #1;
        chk_state("reset", 8'h00, 3'b000, 1'b0, 1'b0);
        #11;
        rst_n = 1'b1;

        // Sequential fetch
        instr_valid = 1'b1;
        chk_state("seq0", 8'h00, 3'b000, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_state($sformatf("seq%0d", i), 8'(i), 3'b000, 1'b0, 1'b0);
        end

        // Zero result sets z, then jz taken
        flags_write = 1'b1;
        alu_result  = 16'h0000;
        step();
        chk_state("fw_zero", 8'h05, 3'b001, 1'b0, 1'b0);
        clear_strobes();
        is_jz  = 1'b1;
        target = 8'h40;
        step();
        chk_state("jz_taken", 8'h40, 3'b001, 1'b1, 1'b1);
        clear_strobes();
        step();
        chk_state("jz_after", 8'h41, 3'b001, 1'b0, 1'b0);

        // Same-cycle flag write and jl: old flags (z) decide, so not taken
        flags_write = 1'b1;
        alu_result  = 16'h8000;
        is_jl       = 1'b1;
        target      = 8'h10;
        step();
        chk_state("jl_oldflags", 8'h42, 3'b010, 1'b0, 1'b0);
        clear_strobes();

        // jnz taken (z=0), then strobes and flag write ignored during FLUSH
        is_jnz = 1'b1;
        target = 8'h80;
        step();
        chk_state("jnz_taken", 8'h80, 3'b010, 1'b1, 1'b1);
        clear_strobes();
        is_jump     = 1'b1;
        flags_write = 1'b1;
        alu_result  = 16'h0000;
        target      = 8'h20;
        step();
        chk_state("flush_ignore", 8'h81, 3'b010, 1'b0, 1'b0);
        clear_strobes();

        // Set z, then jump+jnz: jump wins regardless of z
        flags_write = 1'b1;
        alu_result  = 16'h0000;
        step();
        chk_state("set_z", 8'h82, 3'b001, 1'b0, 1'b0);
        clear_strobes();
        is_jump = 1'b1;
        is_jnz  = 1'b1;
        target  = 8'hF0;
        step();
        chk_state("jump_prio", 8'hF0, 3'b001, 1'b1, 1'b1);
        clear_strobes();
        step();
        chk_state("jump_after", 8'hF1, 3'b001, 1'b0, 1'b0);

        // PC wrap from 0xFF with no branch
        is_jump = 1'b1;
        target  = 8'hFE;
        step();
        chk_state("to_fe", 8'hFE, 3'b001, 1'b1, 1'b1);
        clear_strobes();
        step();
        chk_state("at_ff", 8'hFF, 3'b001, 1'b0, 1'b0);
        step();
        chk_state("wrap", 8'h00, 3'b001, 1'b0, 1'b0);

        // Stall during FLUSH freezes everything
        is_jump = 1'b1;
        target  = 8'h30;
        step();
        chk_state("to_30", 8'h30, 3'b001, 1'b1, 1'b1);
        stall       = 1'b1;
        is_jump     = 1'b1;
        target      = 8'h55;
        flags_write = 1'b1;
        alu_result  = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("stall%0d", i), 8'h30, 3'b001, 1'b1, 1'b1);
        end
        stall = 1'b0;
        clear_strobes();
        step();
        chk_state("unstall", 8'h31, 3'b001, 1'b0, 1'b0);

        // Jump with positive result written, then async reset mid-FLUSH
        is_jump     = 1'b1;
        flags_write = 1'b1;
        alu_result  = 16'h0005;
        target      = 8'h60;
        step();
        chk_state("to_60", 8'h60, 3'b100, 1'b1, 1'b1);
        clear_strobes();
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 3'b000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk_state("post_rst", 8'h01, 3'b000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
